// File: rtl/muladd_pkg.sv
// Shared types and constants for the muladd scheduler slice.
package muladd_pkg;

  localparam int RES_W = 32;

  typedef struct packed {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
  } muladd_op_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

endpackage

// File: rtl/muladd.sv
// Combinational multiply-accumulate: o = c + a*b (s=0) or c - a*b (s=1), wrapping mod 2^32.
module muladd
  import muladd_pkg::*;
(
  input  logic             s,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [31:0]      c,
  output logic [RES_W-1:0] o
);

  logic signed [31:0] prod_s;

  assign prod_s = $signed(a) * $signed(b);
  assign o      = s ? (c - prod_s) : (c + prod_s);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan offsets 1..NREQ from the pointer; the first hit wins.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s        = IW'((int'(ptr) + k) % NREQ);
      hit_s         = !any && valid[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? cand_s : idx;
      any           = any | hit_s;
    end
  end

endmodule

// File: rtl/muladd_sched.sv
// Round-robin scheduler sharing one muladd among NREQ requesters, with bounded
// lock bursts and a fixed two-cycle registered result path.
module muladd_sched
  import muladd_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ-1:0]         req_s,
  input  logic [NREQ*16-1:0]      req_a,
  input  logic [NREQ*16-1:0]      req_b,
  input  logic [NREQ*32-1:0]      req_c,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [RES_W-1:0]        rsp_o
);

  localparam int             IW        = $clog2(NREQ);
  localparam int             CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW:0]    BURST_MAX = (CW + 1)'(MAX_BURST);
  localparam logic           LOCK_EN   = (MAX_BURST > 1) ? 1'b1 : 1'b0;

  sched_state_t    state_r, state_n;
  logic [IW-1:0]   last_r, last_n;
  logic [IW-1:0]   owner_r, owner_n;
  logic [CW-1:0]   count_r, count_n;
  logic [CW:0]     count_inc_s;
  logic            burst_done_s;
  logic            owner_live_s;
  logic            do_arb_s;
  logic            accept_s;
  logic [NREQ-1:0] arb_grant_s;
  logic [IW-1:0]   arb_idx_s;
  logic            arb_any_s;
  logic [IW-1:0]   grant_idx_s;
  muladd_op_t      op_s, op_r;
  logic [IW-1:0]   id_r;
  logic            v1_r;
  logic [RES_W-1:0] mul_o_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .ptr   (last_r),
    .valid (req_valid),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  // Grant selection: a live lock owner pre-empts round-robin arbitration.
  always_comb begin
    owner_live_s = (state_r == LOCKED) && req_valid[owner_r];
    grant_idx_s  = owner_live_s ? owner_r : arb_idx_s;
    if (!rst_n) begin
      req_ready = '0;
    end else if (owner_live_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
    end else begin
      req_ready = arb_grant_s;
    end
    accept_s = |req_ready;
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    op_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      op_s.s = op_s.s | (req_s[k] & req_ready[k]);
      op_s.a = op_s.a | (req_a[k*16 +: 16] & {16{req_ready[k]}});
      op_s.b = op_s.b | (req_b[k*16 +: 16] & {16{req_ready[k]}});
      op_s.c = op_s.c | (req_c[k*32 +: 32] & {32{req_ready[k]}});
    end
  end

  // Next-state: continue a live burst, otherwise arbitrate (abandoning any stale lock).
  always_comb begin
    state_n      = state_r;
    last_n       = last_r;
    owner_n      = owner_r;
    count_n      = count_r;
    count_inc_s  = {1'b0, count_r} + (CW + 1)'(1'b1);
    burst_done_s = (count_inc_s >= BURST_MAX);
    case (state_r)
      LOCKED:  do_arb_s = !owner_live_s;
      ARB:     do_arb_s = 1'b1;
      default: do_arb_s = 1'b1;
    endcase
    if (!do_arb_s) begin
      last_n = owner_r;
      if (!req_lock[owner_r] || burst_done_s) begin
        state_n = ARB;
        count_n = '0;
      end else begin
        state_n = LOCKED;
        count_n = count_inc_s[CW-1:0];
      end
    end else begin
      state_n = ARB;
      count_n = '0;
      if (arb_any_s) begin
        last_n = arb_idx_s;
        if (req_lock[arb_idx_s] && LOCK_EN) begin
          state_n = LOCKED;
          owner_n = arb_idx_s;
          count_n = CW'(1'b1);
        end else begin
          state_n = ARB;
        end
      end else begin
        last_n = last_r;
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      last_r  <= IW'(NREQ - 1);
      owner_r <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_n;
      last_r  <= last_n;
      owner_r <= owner_n;
      count_r <= count_n;
    end
  end

  muladd u_mac (
    .s (op_r.s),
    .a (op_r.a),
    .b (op_r.b),
    .c (op_r.c),
    .o (mul_o_s)
  );

  // Stage 1 captures operands; stage 2 registers the result, holding it when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      id_r      <= '0;
      v1_r      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_o     <= '0;
    end else begin
      v1_r      <= accept_s;
      rsp_valid <= v1_r;
      if (accept_s) begin
        op_r <= op_s;
        id_r <= grant_idx_s;
      end else begin
        op_r <= op_r;
        id_r <= id_r;
      end
      if (v1_r) begin
        rsp_o  <= mul_o_s;
        rsp_id <= id_r;
      end else begin
        rsp_o  <= rsp_o;
        rsp_id <= rsp_id;
      end
    end
  end

endmodule

// File: doc/muladd_sched.md
Name: muladd_sched

Overview:
- Pipelined round-robin scheduler that shares one combinational muladd unit (o = c ± a·b, one SB_MAC16) among NREQ requesters, e.g. filter, mixer and volume stages of the SID datapath.
- Accepts at most one operation per clock.
- Registers the operands, evaluates them through the single muladd instance and returns a tagged, registered result.
- Optional lock lets one requester issue a bounded back-to-back burst, e.g. a filter integrator chain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive grants to one locked requester (1..16).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_lock  in  NREQ  per-requester request to keep grant for the next operation.
- req_s  in  NREQ  per-requester add/subtract select: 0 = add, 1 = subtract.
- req_a  in  NREQ×16  signed multiplicand per requester.
- req_b  in  NREQ×16  signed multiplier per requester.
- req_c  in  NREQ×32  signed addend per requester.
- req_ready  out  NREQ  one-hot grant; an operation is accepted when valid & ready.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  clog2(NREQ)  index of the requester owning rsp_o.
- rsp_o  out  32  signed result c ± a·b (wraps mod 2^32).

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - rsp_valid=0, rsp_o=0, rsp_id=0.
  - Stage-1 regs cleared; stage-1 valid=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - burst count=0, state=ARB.
- req_ready is combinational from req_valid and internal state:
  - At most one bit is set.
  - It is never set for a requester whose req_valid=0.
  - It is all zero while rst_n=0.
- State ARB:
  - Grant goes to the first valid requester searching last+1, last+2, … modulo NREQ.
  - On accept: last←granted index.
  - If req_lock of the winner = 1 and MAX_BURST>1: state←LOCKED, owner←winner, count←1. Otherwise remain in ARB.
- State LOCKED:
  - If the owner has valid=1, it is granted exclusively; all other ready bits = 0.
  - On accept: count←count+1.
  - Owner's lock=0 on an accepted op, or count reaches MAX_BURST: return to ARB after this op.
  - If owner valid=0 this cycle: immediately fall back to ARB arbitration in the same cycle (lock abandoned, count←0). The pointer stays at the owner, so the owner has lowest priority next.
- Pipeline, fixed latency 2:
  - Cycle N, accept: the granted operands are captured into stage-1 regs (a, b, c, s, id, valid).
  - Cycle N+1: muladd evaluates stage-1 regs combinationally.
  - Edge ending N+1: rsp_o, rsp_id and rsp_valid are registered.
  - rsp_valid is high during cycle N+2.
- Throughput: one op per cycle; no backpressure on the response side. Consumers must capture on rsp_valid.
- Idle cycle (no accept): stage-1 valid←0, then rsp_valid←0 the next cycle. rsp_o and rsp_id hold their last values.
- Arithmetic: 16×16 signed product, full 32-bit add or subtract to c, no saturation.
  - Overflow wraps: e.g. c=0x7FFFFFFF, a=b=1, s=0 → 0x80000000.
  - s=1 with a=b=−32768 and c=0 → 0xC0000000.
- Simultaneous requests: exactly one accepted per cycle; the others stall with ready=0 and must hold their operands stable.
- Reset mid-burst or mid-pipeline: in-flight ops are discarded, no rsp_valid is produced for them, and the state returns to ARB.

Decomposition:
- Shared package muladd_pkg:
  - operand struct muladd_op_t {s, a[15:0], b[15:0], c[31:0]}.
  - sched state enum {ARB, LOCKED}.
  - result width constant 32.
- Sub-modules:
  - The existing muladd, instantiated once.
  - One natural sub-module rr_arbiter (NREQ, pointer in, valid mask in, one-hot grant + index out), reusable elsewhere.

Test Plan:
- Reset, then single op from req 1 (a=3, b=−4, c=100, s=0) → ready[1] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_o=88.
- All 4 requesters valid continuously, no lock → grants in order 0,1,2,3,0,…; rsp_id sequence matches; one result per cycle.
- Req 2 lock=1 with 6 back-to-back ops, MAX_BURST=4, others valid → req 2 granted 4 consecutive cycles, then req 3, then 0, 1, then 2 again.
- Req 0 locked, deasserts valid after 2 ops → same cycle grant goes to req 1; req 0 is not re-granted until 1, 2, 3 have been served.
- Arithmetic corners: c=0x7FFFFFFF, a=b=1, s=0 → 0x80000000; c=0, a=b=−32768, s=1 → 0xC0000000; c=5, a=0, s=1 → 5.
- Assert rst_n=0 for 1 cycle while 2 ops are in flight and a lock is active → no rsp_valid afterwards; the next grant goes to req 0 from ARB.
